// File: rtl/ram_pkg.sv
// Shared constants, FSM state type and lane-count helper for the byte-enabled dual-port RAM.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_byte_lane.sv
// One byte-wide storage lane: array write port plus registered read with
// selectable same-address read-during-write behaviour.
module ram_byte_lane
  import ram_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BYTE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BYTE_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BYTE_WIDTH-1:0] mem [DEPTH];
  logic [BYTE_WIDTH-1:0] rdata_reg;
  logic [BYTE_WIDTH-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first forwards the incoming lane value; read-first sees the pre-edge array value.
  always_comb begin
    rd_word = mem[raddr];
    if (RDW_MODE == RDW_WRITE_FIRST && we && (waddr == raddr)) begin
      rd_word = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= rd_word;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple-dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency
// and a hardware zero-fill sequence after every reset.
module dual_port_ram_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             init_done
);

  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
  logic [NUM_BYTES-1:0]    lane_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_accept;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= INIT;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      INIT: begin
        clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
        if (clr_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
          state_next = READY;
        end
      end
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // The clear sequence owns the write port until it finishes; user requests are dropped meanwhile.
  always_comb begin
    lane_we   = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_reg == INIT) begin
      lane_we   = '1;
      mem_waddr = clr_cnt_reg;
      mem_wdata = '0;
    end else if (wr_en) begin
      lane_we = wr_be;
    end
  end

  assign rd_accept = rd_en && (state_reg == READY);
  assign init_done = (state_reg == READY);

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    ram_byte_lane #(
      .BYTE_WIDTH(BYTE_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RDW_MODE  (RDW_MODE)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .we   (lane_we[gi]),
      .waddr(mem_waddr),
      .wdata(mem_wdata[gi*BYTE_WIDTH +: BYTE_WIDTH]),
      .re   (rd_accept),
      .raddr(rd_addr),
      .rdata(s1_data[gi*BYTE_WIDTH +: BYTE_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= rd_accept;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_reg;
    logic                  s2_valid_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s2_data_reg  <= '0;
        s2_valid_reg <= 1'b0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= s1_data;
        end
      end
    end

    assign rd_data  = s2_data_reg;
    assign rd_valid = s2_valid_reg;
  end else begin : g_lat1
    assign rd_data  = s1_data;
    assign rd_valid = s1_valid_reg;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: three RAM variants (read-first, write-first, 2-cycle latency) share one stimulus stream.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] rd_data_rf, rd_data_wf, rd_data_l2;
  logic        rd_valid_rf, rd_valid_wf, rd_valid_l2;
  logic        init_done_rf, init_done_wf, init_done_l2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dual_port_ram_be #(.RD_LATENCY(1), .RDW_MODE(0)) dut_rf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_rf),
    .rd_valid(rd_valid_rf), .init_done(init_done_rf));

  dual_port_ram_be #(.RD_LATENCY(1), .RDW_MODE(1)) dut_wf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_wf),
    .rd_valid(rd_valid_wf), .init_done(init_done_wf));

  dual_port_ram_be #(.RD_LATENCY(2), .RDW_MODE(0)) dut_l2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_l2),
    .rd_valid(rd_valid_l2), .init_done(init_done_l2));

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] exp_rf;
    logic [31:0] exp_wf;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Requests are held asserted through INIT; none may produce a read or a write.
  task automatic run_init();
    int n;
    n = 0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd0;
    while (init_done_rf !== 1'b1 && n < 100) begin
      step();
      n++;
      check("init_no_valid", {29'd0, rd_valid_rf, rd_valid_wf, rd_valid_l2}, 32'd0);
    end
    idle();
    check("init_cycles", n, 32'd16);
    check("init_done_all", {29'd0, init_done_rf, init_done_wf, init_done_l2}, 32'd7);
    $display("init complete after %0d cycles", n);
  endtask

  task automatic sweep_zero();
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      check("sweep_valid", {31'd0, rd_valid_rf}, 32'd1);
      check("sweep_rf", rd_data_rf, 32'd0);
      check("sweep_wf", rd_data_wf, 32'd0);
      $display("sweep addr %0d rf=%h wf=%h", a, rd_data_rf, rd_data_wf);
    end
    idle();
    step();
    check("sweep_l2_last", rd_data_l2, 32'd0);
    step();
  endtask

  initial begin
    logic [31:0] hold_rf, hold_wf, hold_l2, prev_exp;
    logic        prev_rd;

    vecs[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 4'd3, 32'h0000AA00, 4'h2, 1'b0, 4'd0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 32'hDEADAAEF, 32'hDEADAAEF};
    vecs[3]  = '{1'b1, 4'd5, 32'hCAFEF00D, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 4'd5, 32'h11223344, 4'hF, 1'b1, 4'd5, 32'hCAFEF00D, 32'h11223344};
    vecs[5]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5, 32'h11223344, 32'h11223344};
    vecs[6]  = '{1'b1, 4'd5, 32'hCAFEF00D, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 4'd5, 32'h11223344, 4'h1, 1'b1, 4'd5, 32'hCAFEF00D, 32'hCAFEF044};
    vecs[8]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5, 32'hCAFEF044, 32'hCAFEF044};
    vecs[9]  = '{1'b1, 4'd6, 32'h12345678, 4'h0, 1'b1, 4'd6, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd6, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 4'd7, 32'hA5A5A5A5, 4'hF, 1'b1, 4'd3, 32'hDEADAAEF, 32'hDEADAAEF};
    vecs[12] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[13] = '{1'b1, 4'd0, 32'h0F0F0F0F, 4'hC, 1'b1, 4'd0, 32'h0, 32'h0F0F0000};
    vecs[14] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd0, 32'h0F0F0000, 32'h0F0F0000};
    vecs[15] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 32'h0, 32'h0};

    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    #12;
    check("reset_rd_data", rd_data_rf | rd_data_wf | rd_data_l2, 32'd0);
    check("reset_flags", {28'd0, rd_valid_rf, rd_valid_l2, init_done_rf, init_done_l2}, 32'd0);
    step();
    reset = 1'b1;

    run_init();
    sweep_zero();

    hold_rf = '0; hold_wf = '0; hold_l2 = '0; prev_exp = '0; prev_rd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      wr_be = vecs[i].wr_be; rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      step();
      if (vecs[i].rd_en) begin
        hold_rf = vecs[i].exp_rf;
        hold_wf = vecs[i].exp_wf;
      end
      if (prev_rd) hold_l2 = prev_exp;
      check("vec_valid_rf", {31'd0, rd_valid_rf}, {31'd0, vecs[i].rd_en});
      check("vec_valid_wf", {31'd0, rd_valid_wf}, {31'd0, vecs[i].rd_en});
      check("vec_data_rf", rd_data_rf, hold_rf);
      check("vec_data_wf", rd_data_wf, hold_wf);
      check("vec_valid_l2", {31'd0, rd_valid_l2}, {31'd0, prev_rd});
      check("vec_data_l2", rd_data_l2, hold_l2);
      $display("vec %0d wr=%0d a=%0d d=%h be=%h rd=%0d a=%0d -> rf=%h wf=%h l2=%h",
               i, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_be,
               vecs[i].rd_en, vecs[i].rd_addr, rd_data_rf, rd_data_wf, rd_data_l2);
      prev_rd  = vecs[i].rd_en;
      prev_exp = vecs[i].exp_rf;
    end
    idle();

    // 2-cycle latency burst: three back-to-back reads give three consecutive valid cycles.
    for (int a = 0; a < 3; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 32'h100 + 32'(a); wr_be = 4'hF;
      step();
    end
    idle();
    for (int a = 0; a < 3; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      check("burst_valid", {31'd0, rd_valid_l2}, (a == 0) ? 32'd0 : 32'd1);
      if (a > 0) check("burst_data", rd_data_l2, 32'h100 + 32'(a - 1));
      $display("burst issue addr %0d l2 valid=%0d data=%h", a, rd_valid_l2, rd_data_l2);
    end
    idle();
    step();
    check("burst_valid_tail", {31'd0, rd_valid_l2}, 32'd1);
    check("burst_data_tail", rd_data_l2, 32'h102);
    step();
    check("burst_valid_end", {31'd0, rd_valid_l2}, 32'd0);
    check("burst_data_hold", rd_data_l2, 32'h102);

    // Reset during an in-flight read.
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h55555555; wr_be = 4'hF;
    step();
    idle();
    rd_en = 1'b1; rd_addr = 4'd4;
    step();
    idle();
    check("inflight_pre_valid", {31'd0, rd_valid_rf}, 32'd1);
    check("inflight_pre_data", rd_data_rf, 32'h55555555);
    #2 reset = 1'b0;
    #1;
    check("inflight_rst_valid", {30'd0, rd_valid_rf, rd_valid_wf}, 32'd0);
    check("inflight_rst_data", rd_data_rf | rd_data_wf, 32'd0);
    check("inflight_rst_done", {31'd0, init_done_rf}, 32'd0);
    step();
    step();
    check("inflight_l2_dropped", {31'd0, rd_valid_l2}, 32'd0);
    $display("reset during in-flight read applied");
    reset = 1'b1;

    // Reset in the middle of INIT, then a full INIT again.
    for (int c = 0; c < 7; c++) step();
    check("midinit_not_done", {31'd0, init_done_rf}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("midinit_rst_flags", {29'd0, init_done_rf, rd_valid_rf, rd_valid_l2}, 32'd0);
    step();
    $display("reset at init cycle 7 applied");
    reset = 1'b1;
    run_init();
    sweep_zero();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
